// File: rtl/bits_tracker_if.sv
// Sample-beat stream into the tracker and decided-symbol/timing status out of it.
interface bits_tracker_if #(
  parameter int CORR_W = 4,
  parameter int NSYM   = 4,
  parameter int PER_W  = 6
);
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;

  logic [NSYM*CORR_W-1:0] in_corr;
  logic                   in_vld;
  logic [SYM_W-1:0]       out_sym;
  logic                   out_dat;
  logic                   out_vld;
  logic [1:0]             out_adj;
  logic                   adj_sat;
  logic                   locked;
  logic [PER_W-1:0]       period;

  modport master (
    output in_corr, in_vld,
    input  out_sym, out_dat, out_vld, out_adj, adj_sat, locked, period
  );

  modport slave (
    input  in_corr, in_vld,
    output out_sym, out_dat, out_vld, out_adj, adj_sat, locked, period
  );
endinterface

// File: rtl/bits_tracker.sv
// Argmax symbol decision over an NSYM-way correlator bank, with early/late gate
// timing recovery, a period bounded around nominal, and a lock indicator.
module bits_tracker #(
  parameter int CORR_W      = 4,
  parameter int NSYM        = 4,
  parameter int PER_W       = 6,
  parameter int LOCK_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [PER_W-1:0] cfg_tol,
  input  logic [1:0]       cfg_el,
  bits_tracker_if.slave    bus
);
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int LCK_W = $clog2(LOCK_THRESH + 1);
  localparam int EW    = PER_W + 1;

  logic [CORR_W-1:0] w_corr  [NSYM];
  logic [CORR_W-1:0] r_on    [NSYM];
  logic [CORR_W-1:0] r_early [NSYM];
  logic [CORR_W-1:0] r_late  [NSYM];

  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_cnt;
  logic [EW-1:0]    r_pmin;
  logic [EW-1:0]    r_pmax;
  logic [1:0]       r_el;
  logic             r_dec_pend;
  logic             r_trk_pend;
  logic             r_decided;
  logic [LCK_W-1:0] r_lock_cnt;
  logic [SYM_W-1:0] r_sym;
  logic             r_dat;
  logic             r_vld;
  logic [1:0]       r_adj;
  logic             r_sat;
  logic             r_locked;

  logic             w_srst;
  logic             w_on_stb;
  logic             w_late_stb;
  logic             w_early_stb;
  logic             w_wrap;
  logic [EW-1:0]    w_cnt_p1;
  logic [EW-1:0]    w_per_e;
  logic [EW-1:0]    w_pmax_raw;
  logic [EW-1:0]    w_pmax_cfg;
  logic [SYM_W-1:0] w_best_sym;
  logic [CORR_W-1:0] w_best_val;
  logic             w_best_dat;
  logic [CORR_W-1:0] w_on_s;
  logic [CORR_W-1:0] w_early_s;
  logic [CORR_W-1:0] w_late_s;
  logic             w_hold;
  logic             w_up;
  logic [EW-1:0]    w_target;
  logic [EW-1:0]    w_clamped;
  logic             w_sat;
  logic [1:0]       w_adj;
  logic [LCK_W-1:0] w_lock_next;

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_slice
    assign w_corr[gi] = bus.in_corr[gi*CORR_W +: CORR_W];
  end

  assign w_srst      = rst | restart;
  assign w_cnt_p1    = {1'b0, r_cnt} + EW'(1);
  assign w_per_e     = {1'b0, r_period};
  assign w_wrap      = (w_cnt_p1 >= w_per_e);
  assign w_on_stb    = bus.in_vld && (w_cnt_p1 == w_per_e);
  assign w_late_stb  = bus.in_vld && (r_el != 2'd0) && (w_cnt_p1 == EW'(r_el));
  assign w_early_stb = bus.in_vld && (r_el != 2'd0) && ((w_cnt_p1 + EW'(r_el)) == w_per_e);

  // Upper bound saturates at the largest representable period.
  assign w_pmax_raw = {1'b0, cfg_period} + {1'b0, cfg_tol};
  assign w_pmax_cfg = w_pmax_raw[PER_W] ? {1'b0, {PER_W{1'b1}}} : w_pmax_raw;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best_sym = '0;
    w_best_val = r_on[0];
    for (int k = 1; k < NSYM; k++) begin
      if (r_on[k] > w_best_val) begin
        w_best_val = r_on[k];
        w_best_sym = SYM_W'(k);
      end
    end
  end
  assign w_best_dat = (w_best_sym == '0) || (w_best_sym == SYM_W'(NSYM - 1));

  assign w_on_s    = r_on[r_sym];
  assign w_early_s = r_early[r_sym];
  assign w_late_s  = r_late[r_sym];
  assign w_hold    = (w_on_s >= w_early_s) && (w_on_s >= w_late_s);
  assign w_up      = (w_late_s >= w_early_s);

  always_comb begin
    w_target = w_per_e;
    w_adj    = 2'b00;
    if (!w_hold) begin
      w_target = w_up ? (w_per_e + EW'(r_el)) : (w_per_e - EW'(r_el));
      w_adj    = w_up ? 2'b01 : 2'b11;
    end
    w_clamped = w_target;
    if (w_target < r_pmin) w_clamped = r_pmin;
    else if (w_target > r_pmax) w_clamped = r_pmax;
  end
  assign w_sat = (w_clamped != w_target);

  always_comb begin
    w_lock_next = r_lock_cnt;
    if (w_sat) w_lock_next = '0;
    else if (w_hold && (r_lock_cnt != LCK_W'(LOCK_THRESH))) w_lock_next = r_lock_cnt + LCK_W'(1);
  end

  always_ff @(posedge clk) begin
    r_vld <= 1'b0;
    r_sat <= 1'b0;
    if (w_srst) begin
      r_period   <= cfg_period;
      r_pmin     <= {1'b0, cfg_period} - {1'b0, cfg_tol};
      r_pmax     <= w_pmax_cfg;
      r_el       <= cfg_el;
      r_cnt      <= '0;
      r_dec_pend <= 1'b0;
      r_trk_pend <= 1'b0;
      r_decided  <= 1'b0;
      r_lock_cnt <= '0;
      r_sym      <= '0;
      r_dat      <= 1'b0;
      r_adj      <= 2'b00;
      r_locked   <= 1'b0;
      for (int k = 0; k < NSYM; k++) begin
        r_on[k]    <= '1;
        r_early[k] <= '0;
        r_late[k]  <= '0;
      end
    end else begin
      if (bus.in_vld) r_cnt <= w_wrap ? '0 : w_cnt_p1[PER_W-1:0];
      if (w_on_stb)    r_on    <= w_corr;
      if (w_early_stb) r_early <= w_corr;
      if (w_late_stb)  r_late  <= w_corr;
      r_dec_pend <= w_on_stb;
      r_trk_pend <= w_late_stb;
      if (r_dec_pend) begin
        r_sym     <= w_best_sym;
        r_dat     <= w_best_dat;
        r_vld     <= 1'b1;
        r_decided <= 1'b1;
      end
      if (r_trk_pend && r_decided) begin
        r_period   <= w_clamped[PER_W-1:0];
        r_adj      <= w_adj;
        r_sat      <= w_sat;
        r_lock_cnt <= w_lock_next;
        r_locked   <= (w_lock_next == LCK_W'(LOCK_THRESH));
      end
    end
  end

  assign bus.out_sym = r_sym;
  assign bus.out_dat = r_dat;
  assign bus.out_vld = r_vld;
  assign bus.out_adj = r_adj;
  assign bus.adj_sat = r_sat;
  assign bus.locked  = r_locked;
  assign bus.period  = r_period;
endmodule

// File: doc/bits_tracker.md
# bits_tracker

Parameterised successor to the FM0/Miller bit detector. It takes per-beat correlation vectors from an external NSYM-way symbol correlator bank and tracks symbol timing with runtime-configurable early/late gates. It bounds the tracked period to a tolerance window around nominal and reports lock. It sits between the correlator bank and the frame/CRC stage of the tag-reply receive path.

## Interface
- CORR_W, 4, width of one correlation value (unsigned)
- NSYM, 4, number of candidate symbols (>=2)
- PER_W, 6, width of period/counter arithmetic
- LOCK_THRESH, 8, consecutive no-adjust decisions required for lock (>=1)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- restart  in  1  synchronous re-acquire pulse; same effect as rst on internal state
- in_corr  in  NSYM*CORR_W  correlations, symbol k at [k*CORR_W +: CORR_W]
- in_vld  in  1  in_corr valid this cycle (one sample beat)
- cfg_period  in  PER_W  nominal samples per symbol
- cfg_tol  in  PER_W  max deviation of tracked period from nominal
- cfg_el  in  2  early/late gate offset and step size; 0 disables tracking
- out_sym  out  $clog2(NSYM)  decided symbol index
- out_dat  out  1  decoded bit: 1 iff out_sym==0 or out_sym==NSYM-1
- out_vld  out  1  one-cycle pulse, out_sym/out_dat new
- out_adj  out  2  last adjustment: 00 none, 01 late (+), 11 early (-)
- adj_sat  out  1  one-cycle pulse, requested adjustment was clamped
- locked  out  1  lock indicator
- period  out  PER_W  current tracked period

## Operation
- cfg_period, cfg_tol, cfg_el are captured into internal registers on rst or restart only. Legal config: cfg_period - cfg_tol >= 2*cfg_el + 2. Behaviour outside this is undefined.
- Bounds: pmin = cfg_period - cfg_tol; pmax = min(cfg_period + cfg_tol, 2^PER_W - 1), computed at PER_W+1 bits.
- Counter `cnt` advances only on in_vld. On in_vld with cnt >= period-1, cnt wraps to 0. The >= covers a period shrink past cnt.
- Strobes are qualified by in_vld:
  - on-time: cnt == period-1
  - late: cnt == el-1
  - early: cnt == period-el-1
- Each strobe captures in_corr into its own register. Disabled when el==0.
- Decision, on the cycle after an on-time capture:
  - out_sym = argmax of captured on-time values; ties go to the lowest index.
  - out_dat is derived from out_sym.
  - out_vld is pulsed.
  - A decided flag is set.
- Tracking runs the cycle after a late capture, only if the decided flag is set and el != 0. Let s = out_sym, with on/early/late values taken for symbol s:
  - on >= early and on >= late: no change, out_adj = 00.
  - else late >= early: target = period + el, out_adj = 01.
  - else: target = period - el, out_adj = 11.
  - Target is clamped to [pmin, pmax]. If clamping changed it, pulse adj_sat.
  - The period update is persistent.
- Lock counter, updated at each tracking evaluation:
  - out_adj == 00: increment, saturating at LOCK_THRESH.
  - Adjustment applied unclamped: hold.
  - adj_sat: clear to 0.
  - locked = (counter == LOCK_THRESH).
- rst/restart clears: cnt, decided flag, lock counter. Period reloads from the new cfg_period. Early/late registers clear to 0; on-time registers go to all-ones. Any in-flight decision or tracking step is discarded.

## Timing
- Reset values: out_sym=0, out_dat=0, out_vld=0, out_adj=00, adj_sat=0, locked=0, period=cfg_period (the value sampled in the rst cycle).
- Decision latency: on-time capture at edge E0, out_vld high for the single cycle after edge E1.
- Tracking latency: late capture at edge L0, period/out_adj/adj_sat/locked update at edge L1. The new period is in effect from the next in_vld.
- When in_vld is high every cycle and el==1, the decision (E1) and the late capture coincide at the same edge. The tracking step at the following edge uses the newly decided out_sym.
- in_vld gaps freeze cnt and all strobes. Pending decision/tracking steps still complete on their fixed one-cycle delay.
- restart asserted in the same cycle as a strobe: restart wins, nothing is captured, no out_vld.
- Outputs are registered; no combinational input-to-output path.

## Test plan
- cfg_period=8, cfg_el=1, cfg_tol=2, in_vld=1, symbol 2 peaking at cnt 7 -> out_vld every 8 cycles, out_sym=2, out_dat=0, period=8, locked=1 after the 8th decision.
- Same config, peak drifting to cnt 0 (late gate largest) -> out_adj=01, period 9 then 10; the third late request clamps: period=10, adj_sat pulse, lock counter 0.
- All correlations equal -> out_sym=0, out_dat=1, out_adj=00; symbol NSYM-1 peaking -> out_dat=1.
- in_vld toggling 1/0 -> out_vld every 16 clk, cnt held during gaps, same decisions as the continuous case.
- restart asserted at cnt=5 with cfg_period changed to 12 -> no out_vld for the partial symbol, period=12, locked=0, first out_vld 2 clk after the 12th subsequent in_vld.
- cfg_el=0 -> period never changes, out_adj stays 00, locked rises after LOCK_THRESH decisions only if tracking is enabled (stays 0 here).
